// File: rtl/regfile_checker.sv
// regfile_checker: shadows the CPU register-file writeback port while a test
// program runs, then walks a programmable table of expected register values
// and reports pass/fail, the number of mismatches and the first failing entry.
module regfile_checker #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int CIW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int FCW = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              halt,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              cfg_we,
    input  logic [CIW-1:0]    cfg_idx,
    input  logic              cfg_valid,
    input  logic [REG_AW-1:0] cfg_rd,
    input  logic [XLEN-1:0]   cfg_val,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [FCW-1:0]    fail_count,
    output logic [CIW-1:0]    first_fail_idx,
    output logic [XLEN-1:0]   first_fail_got
);

    localparam int NREGS = 2 ** REG_AW;
    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CIW-1:0] CHK_LAST  = CIW'(NUM_CHECKS - 1);
    localparam logic [CIW:0]   CHK_COUNT = (CIW + 1)'(NUM_CHECKS);
    localparam logic [FCW-1:0] FAIL_MAX  = FCW'(NUM_CHECKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [XLEN-1:0]   r_shadow [NREGS];
    logic [NUM_CHECKS-1:0] r_tabValid;
    logic [REG_AW-1:0] r_tabRd  [NUM_CHECKS];
    logic [XLEN-1:0]   r_tabVal [NUM_CHECKS];

    logic [CW-1:0]     r_cycleCnt;
    logic [CIW-1:0]    r_chkIdx;
    logic              r_pass;
    logic              r_timedOut;
    logic [FCW-1:0]    r_failCnt;
    logic [CIW-1:0]    r_firstIdx;
    logic [XLEN-1:0]   r_firstGot;

    logic              w_enterRun;
    logic              w_cycleLast;
    logic              w_timeoutHit;
    logic              w_checkLast;
    logic              w_cfgAccept;
    logic [REG_AW-1:0] w_chkRd;
    logic [XLEN-1:0]   w_shadowVal;
    logic              w_entryMismatch;
    logic [FCW-1:0]    w_failCntNext;

    assign w_enterRun   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cycleLast  = (r_cycleCnt == TO_LAST);
    assign w_timeoutHit = (r_state == ST_RUN) && !halt && w_cycleLast;
    assign w_checkLast  = (r_state == ST_CHECK) && (r_chkIdx == CHK_LAST);
    assign w_cfgAccept  = cfg_we && (r_state != ST_CHECK) && ({1'b0, cfg_idx} < CHK_COUNT);

    // x0 is hard-wired to zero regardless of what the shadow array holds
    assign w_chkRd     = r_tabRd[r_chkIdx];
    assign w_shadowVal = (w_chkRd == '0) ? '0 : r_shadow[w_chkRd];

    assign w_entryMismatch = (r_state == ST_CHECK) && r_tabValid[r_chkIdx]
                             && (w_shadowVal != r_tabVal[r_chkIdx]);
    assign w_failCntNext   = (w_entryMismatch && (r_failCnt != FAIL_MAX))
                             ? r_failCnt + 1'b1 : r_failCnt;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; halt takes priority over the timeout
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_RUN;
            ST_RUN:   if (halt || w_cycleLast) w_nextState = ST_CHECK;
            ST_CHECK: if (w_checkLast) w_nextState = ST_DONE;
            ST_DONE:  if (start) w_nextState = ST_RUN;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // RUN-state cycle counter used for the timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cycleCnt <= '0;
        end else if (w_enterRun) begin
            r_cycleCnt <= '0;
        end else if ((r_state == ST_RUN) && !w_cycleLast) begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
        end
    end

    // table walk index, one entry per CHECK cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_chkIdx <= '0;
        end else if ((r_state == ST_CHECK) && !w_checkLast) begin
            r_chkIdx <= r_chkIdx + 1'b1;
        end else begin
            r_chkIdx <= '0;
        end
    end

    // shadow register file: cleared on a new run, updated only while in RUN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_enterRun) begin
            for (int i = 0; i < NREGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if ((r_state == ST_RUN) && wb_en && (wb_rd != '0)) begin
            r_shadow[wb_rd] <= wb_data;
        end
    end

    // expected-table enable bits; these are the only table bits that reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tabValid <= '0;
        end else if (w_cfgAccept) begin
            r_tabValid[cfg_idx] <= cfg_valid;
        end
    end

    // expected-table register index and value fields
    always_ff @(posedge clk) begin
        if (w_cfgAccept) begin
            r_tabRd[cfg_idx]  <= cfg_rd;
            r_tabVal[cfg_idx] <= cfg_val;
        end
    end

    // result registers: cleared on a new run, accumulated during CHECK
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pass     <= 1'b0;
            r_timedOut <= 1'b0;
            r_failCnt  <= '0;
            r_firstIdx <= '0;
            r_firstGot <= '0;
        end else if (w_enterRun) begin
            r_pass     <= 1'b0;
            r_timedOut <= 1'b0;
            r_failCnt  <= '0;
            r_firstIdx <= '0;
            r_firstGot <= '0;
        end else begin
            if (w_timeoutHit) begin
                r_timedOut <= 1'b1;
            end
            if (r_state == ST_CHECK) begin
                r_failCnt <= w_failCntNext;
                if (w_entryMismatch && (r_failCnt == '0)) begin
                    r_firstIdx <= r_chkIdx;
                    r_firstGot <= w_shadowVal;
                end
                if (w_checkLast) begin
                    r_pass <= (w_failCntNext == '0) && !r_timedOut;
                end
            end
        end
    end

    assign busy           = (r_state == ST_RUN) || (r_state == ST_CHECK);
    assign done           = (r_state == ST_DONE);
    assign pass           = r_pass;
    assign timed_out      = r_timedOut;
    assign fail_count     = r_failCnt;
    assign first_fail_idx = r_firstIdx;
    assign first_fail_got = r_firstGot;

endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker: directed and randomized scenarios for regfile_checker,
// checked against a behavioural model of the shadow registers and table.
module tb_regfile_checker;

    localparam int XLEN           = 32;
    localparam int REG_AW         = 5;
    localparam int NUM_CHECKS     = 5;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int CIW            = 3;
    localparam int FCW            = 3;

    logic              clk;
    logic              resetn;
    logic              start;
    logic              halt;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              cfg_we;
    logic [CIW-1:0]    cfg_idx;
    logic              cfg_valid;
    logic [REG_AW-1:0] cfg_rd;
    logic [XLEN-1:0]   cfg_val;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timed_out;
    logic [FCW-1:0]    fail_count;
    logic [CIW-1:0]    first_fail_idx;
    logic [XLEN-1:0]   first_fail_got;

    regfile_checker #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .halt(halt),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_rd(cfg_rd), .cfg_val(cfg_val),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_got(first_fail_got)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cmpCount = 0;
    int failCount = 0;

    // behavioural model: register contents, table, and run bookkeeping
    logic [XLEN-1:0] mShadow [32];
    bit              mValid [NUM_CHECKS];
    int              mRd [NUM_CHECKS];
    logic [XLEN-1:0] mVal [NUM_CHECKS];
    bit              mInRun;
    int              mRunCycles;
    bit              mTimedOut;
    int              expFails;
    int              expFirstIdx;
    logic [XLEN-1:0] expFirstGot;
    bit              expPass;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mShadow[i] = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            mValid[i] = 0; mRd[i] = 0; mVal[i] = '0;
        end
        mInRun = 0; mRunCycles = 0; mTimedOut = 0;
    endtask

    task automatic modelEvaluate();
        expFails = 0; expFirstIdx = 0; expFirstGot = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (mValid[i] && (mShadow[mRd[i]] !== mVal[i])) begin
                if (expFails == 0) begin
                    expFirstIdx = i;
                    expFirstGot = mShadow[mRd[i]];
                end
                expFails++;
            end
        end
        expPass = (expFails == 0) && !mTimedOut;
    endtask

    // one clock cycle of writeback/halt stimulus, mirrored into the model
    task automatic applyStimulus(input bit en, input int rd, input logic [XLEN-1:0] data, input bit h);
        wb_en = en; wb_rd = rd[REG_AW-1:0]; wb_data = data; halt = h;
        tick();
        wb_en = 0; wb_rd = '0; wb_data = '0; halt = 0;
        if (mInRun) begin
            if (en && rd != 0) mShadow[rd] = data;
            mRunCycles++;
            if (h) begin
                mInRun = 0; mTimedOut = 0;
            end else if (mRunCycles == TIMEOUT_CYCLES) begin
                mInRun = 0; mTimedOut = 1;
            end
        end
    endtask

    task automatic cfgWrite(input int idx, input bit v, input int rd, input logic [XLEN-1:0] val);
        cfg_we = 1; cfg_idx = idx[CIW-1:0]; cfg_valid = v; cfg_rd = rd[REG_AW-1:0]; cfg_val = val;
        applyStimulus(0, 0, '0, 0);
        cfg_we = 0; cfg_valid = 0;
        if (idx < NUM_CHECKS) begin
            mValid[idx] = v; mRd[idx] = rd; mVal[idx] = val;
        end
    endtask

    task automatic startRun();
        start = 1;
        tick();
        start = 0;
        if (mInRun) begin
            mRunCycles++;
        end else begin
            for (int i = 0; i < 32; i++) mShadow[i] = '0;
            mInRun = 1; mRunCycles = 0; mTimedOut = 0;
        end
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        cmpCount++;
        if (done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL done_wait: done=%0b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic programPlanTable();
        cfgWrite(0, 1, 10, 32'h0000_07FF);
        cfgWrite(1, 1, 11, 32'hFFFF_F800);
        cfgWrite(2, 1, 12, 32'h0000_07FF);
        cfgWrite(3, 1, 13, 32'h8000_0000);
        cfgWrite(4, 1, 14, 32'h0000_0001);
    endtask

    task automatic runPlanData(input logic [XLEN-1:0] v11, input logic [XLEN-1:0] v13);
        applyStimulus(1, 10, 32'h0000_07FF, 0);
        applyStimulus(1, 11, v11, 0);
        applyStimulus(1, 12, 32'h0000_07FF, 0);
        applyStimulus(1, 13, v13, 0);
        applyStimulus(1, 14, 32'h0000_0001, 0);
        applyStimulus(0, 0, '0, 1);
    endtask

    task automatic test_reset();
        int n;
        resetn = 0; start = 0; halt = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
        cfg_we = 0; cfg_idx = '0; cfg_valid = 0; cfg_rd = '0; cfg_val = '0;
        modelReset();
        #12;
        cmpCount++;
        if ({busy, done, pass, timed_out, fail_count, first_fail_idx, first_fail_got} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: busy=%0b done=%0b pass=%0b to=%0b fc=%0d ffi=%0d ffg=%h, required all 0",
                     busy, done, pass, timed_out, fail_count, first_fail_idx, first_fail_got);
        end
        @(negedge clk);
        resetn = 1;
        startRun();
        applyStimulus(1, 5, 32'h1234_5678, 1);
        waitDone(n);
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_empty_table: pass=%0b fc=%0d, required pass=1 fc=0", pass, fail_count);
        end
    endtask

    task automatic test_plan_pass();
        int n;
        programPlanTable();
        startRun();
        runPlanData(32'hFFFF_F800, 32'h8000_0000);
        cmpCount++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL plan_busy: busy=%0b done=%0b, required busy=1 done=0", busy, done);
        end
        waitDone(n);
        cmpCount++;
        if (n + 1 !== 6) begin
            failCount++;
            $display("[TB] FAIL plan_latency: got %0d cycles, required 6", n + 1);
        end
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0 || timed_out !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL plan_result: pass=%0b fc=%0d to=%0b, required 1/0/0", pass, fail_count, timed_out);
        end
    endtask

    task automatic test_mismatch();
        int n;
        startRun();
        runPlanData(32'h0000_0000, 32'h7FFF_FFFF);
        waitDone(n);
        cmpCount++;
        if (fail_count !== 3'd2 || pass !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mismatch_count: fc=%0d pass=%0b, required fc=2 pass=0", fail_count, pass);
        end
        cmpCount++;
        if (first_fail_idx !== 3'd1 || first_fail_got !== 32'h0000_0000) begin
            failCount++;
            $display("[TB] FAIL mismatch_first: idx=%0d got=%h, required idx=1 got=00000000", first_fail_idx, first_fail_got);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        startRun();
        runPlanData(32'hFFFF_F800, 32'h8000_0000);
        waitDone(n);
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0 || first_fail_idx !== 3'd0 || first_fail_got !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL back_to_back: pass=%0b fc=%0d ffi=%0d ffg=%h, required 1/0/0/0",
                     pass, fail_count, first_fail_idx, first_fail_got);
        end
    endtask

    task automatic test_timeout(input bit haltAtLast);
        int n;
        startRun();
        applyStimulus(1, 10, 32'h0000_07FF, 0);
        applyStimulus(1, 11, 32'hFFFF_F800, 0);
        applyStimulus(1, 12, 32'h0000_07FF, 0);
        applyStimulus(1, 13, 32'h8000_0000, 0);
        for (int i = 0; i < TIMEOUT_CYCLES - 5; i++) applyStimulus(0, 0, '0, 0);
        applyStimulus(1, 14, 32'h0000_0001, haltAtLast);
        applyStimulus(1, 10, 32'h0000_0BAD, 0);
        cmpCount++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_check_state: busy=%0b done=%0b, required busy=1 done=0", busy, done);
        end
        waitDone(n);
        cmpCount++;
        if (n !== NUM_CHECKS - 1) begin
            failCount++;
            $display("[TB] FAIL timeout_latency: got %0d cycles, required %0d", n, NUM_CHECKS - 1);
        end
        modelEvaluate();
        cmpCount++;
        if (timed_out !== mTimedOut || pass !== expPass || fail_count !== 3'(expFails)) begin
            failCount++;
            $display("[TB] FAIL timeout_result(halt=%0b): to=%0b pass=%0b fc=%0d, required %0b/%0b/%0d",
                     haltAtLast, timed_out, pass, fail_count, mTimedOut, expPass, expFails);
        end
    endtask

    task automatic test_x0_and_halt_writeback();
        int n;
        cfgWrite(0, 1, 0, 32'h0000_0000);
        cfgWrite(1, 1, 10, 32'hCAFE_F00D);
        cfgWrite(2, 1, 11, 32'h1234_5678);
        cfgWrite(3, 0, 0, 32'h0);
        cfgWrite(4, 0, 0, 32'h0);
        startRun();
        applyStimulus(1, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(1, 11, 32'h1234_5678, 0);
        startRun();
        applyStimulus(1, 10, 32'hCAFE_F00D, 1);
        waitDone(n);
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL x0_halt_wb: pass=%0b fc=%0d ffi=%0d ffg=%h, required pass=1 fc=0",
                     pass, fail_count, first_fail_idx, first_fail_got);
        end
    endtask

    task automatic test_reset_mid_check();
        int n;
        programPlanTable();
        startRun();
        runPlanData(32'h0000_0000, 32'h8000_0000);
        tick();
        tick();
        cmpCount++;
        if (busy !== 1'b1 || fail_count !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL midcheck_pre: busy=%0b fc=%0d, required busy=1 fc=1", busy, fail_count);
        end
        #2 resetn = 0;
        #1;
        cmpCount++;
        if ({busy, done, pass, timed_out, fail_count, first_fail_idx, first_fail_got} !== '0) begin
            failCount++;
            $display("[TB] FAIL midcheck_reset: busy=%0b done=%0b pass=%0b fc=%0d ffi=%0d, required all 0",
                     busy, done, pass, fail_count, first_fail_idx);
        end
        modelReset();
        @(negedge clk);
        resetn = 1;
        startRun();
        runPlanData(32'h0000_0000, 32'h7FFF_FFFF);
        waitDone(n);
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL midcheck_table_cleared: pass=%0b fc=%0d, required pass=1 fc=0", pass, fail_count);
        end
        programPlanTable();
        startRun();
        runPlanData(32'hFFFF_F800, 32'h8000_0000);
        waitDone(n);
        cmpCount++;
        if (pass !== 1'b1 || fail_count !== 3'd0 || timed_out !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midcheck_clean_run: pass=%0b fc=%0d to=%0b, required 1/0/0", pass, fail_count, timed_out);
        end
    endtask

    task automatic test_random();
        int n;
        int nWb;
        for (int iter = 0; iter < 10; iter++) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                cfgWrite(i, $urandom_range(0, 3) != 0, $urandom_range(0, 7), 32'($urandom_range(0, 3)));
            end
            cfgWrite($urandom_range(NUM_CHECKS, 7), 1, $urandom_range(1, 7), 32'hFFFF_0000);
            startRun();
            nWb = $urandom_range(2, 10);
            for (int k = 0; k < nWb; k++) begin
                if (k == 1) cfgWrite($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                                     32'($urandom_range(0, 3)));
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7), 32'($urandom_range(0, 3)), 0);
            end
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), 32'($urandom_range(0, 3)), 1);
            waitDone(n);
            modelEvaluate();
            cmpCount++;
            if (n !== NUM_CHECKS) begin
                failCount++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d, required %0d", iter, n, NUM_CHECKS);
            end
            cmpCount++;
            if (pass !== expPass || fail_count !== 3'(expFails) || timed_out !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL rand_result[%0d]: pass=%0b fc=%0d to=%0b, required %0b/%0d/0",
                         iter, pass, fail_count, timed_out, expPass, expFails);
            end
            cmpCount++;
            if (first_fail_idx !== 3'(expFirstIdx) || first_fail_got !== expFirstGot) begin
                failCount++;
                $display("[TB] FAIL rand_first[%0d]: idx=%0d got=%h, required idx=%0d got=%h",
                         iter, first_fail_idx, first_fail_got, expFirstIdx, expFirstGot);
            end
        end
    endtask

    // scenario sequence and summary
    initial begin
        test_reset();
        test_plan_pass();
        test_mismatch();
        test_back_to_back();
        test_timeout(0);
        test_timeout(1);
        test_x0_and_halt_writeback();
        test_reset_mid_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_checker.md
Name: regfile_checker

Overview:
- Synthesizable, parametrised self-checking monitor for CPU instruction tests.
- Snoops the CPU register-file writeback port and keeps a shadow copy of the architectural registers.
- On program halt or timeout, sequentially compares a programmable table of expected register values against the shadow, then reports pass/fail, mismatch count and first-failure detail.
- Sits beside the cpu instance in instruction-test benches and FPGA bring-up builds, replacing hand-written per-register assertions.

Parameters:
- XLEN, 32, data width of registers and expected values.
- REG_AW, 5, register index width; the shadow holds 2**REG_AW registers.
- NUM_CHECKS, 8, number of expected-value table entries.
- TIMEOUT_CYCLES, 1000, maximum RUN-state cycles before a forced check; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears shadow and results, enters RUN.
- halt  in  1  program finished; level or pulse, sampled only in RUN.
- wb_en  in  1  register writeback valid.
- wb_rd  in  REG_AW  writeback destination index.
- wb_data  in  XLEN  writeback data.
- cfg_we  in  1  expected-table write strobe.
- cfg_idx  in  $clog2(NUM_CHECKS)  table entry index.
- cfg_valid  in  1  entry enabled.
- cfg_rd  in  REG_AW  register to check.
- cfg_val  in  XLEN  expected value.
- busy  out  1  high in RUN or CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done.
- timed_out  out  1  RUN ended by timeout.
- fail_count  out  $clog2(NUM_CHECKS+1)  number of mismatching enabled entries.
- first_fail_idx  out  $clog2(NUM_CHECKS)  lowest failing entry index.
- first_fail_got  out  XLEN  shadow value at the first failure.

Behaviour:
- Reset: FSM to IDLE; all shadow registers, table valid bits and outputs cleared to 0. The table's rd and val fields are not reset.
- FSM states:
  - IDLE: start goes to RUN.
  - RUN: halt goes to CHECK. Otherwise, when the cycle counter reaches TIMEOUT_CYCLES-1, go to CHECK with timed_out set.
  - CHECK: after NUM_CHECKS cycles, go to DONE.
  - DONE: start goes to RUN.
  - start is ignored in RUN and CHECK.
- On entering RUN: shadow, cycle counter, fail_count, first_fail_*, timed_out and pass all cleared. The table is retained.
- Shadow update in RUN: if wb_en and wb_rd != 0, then shadow[wb_rd] <= wb_data.
  - Writebacks to x0 are ignored, and x0 always reads 0.
  - A writeback in the same cycle as halt or timeout is captured.
  - Writebacks in IDLE, CHECK and DONE are ignored, so the shadow is frozen.
- Halt and timeout in the same cycle: halt wins and timed_out = 0.
- CHECK evaluates one entry per cycle, index 0 to NUM_CHECKS-1. Disabled entries still take one cycle and are not compared.
  - On mismatch: fail_count increments.
  - On the first mismatch only: first_fail_idx and first_fail_got are loaded.
  - fail_count saturates at NUM_CHECKS; this cannot overflow given its width.
- Entering DONE: pass = (fail_count == 0) && !timed_out, using the final count. done rises on the first DONE cycle.
  - Latency from the halt cycle to done is NUM_CHECKS+1 cycles.
- Config writes:
  - Accepted in IDLE, RUN and DONE; ignored in CHECK.
  - Out-of-range cfg_idx is ignored.
  - A write in RUN takes effect for the coming CHECK.
- Reset asserted mid-RUN or mid-CHECK: immediate return to IDLE with all outputs 0. Table valid bits are cleared, so the table must be reprogrammed.

Test Plan:
- Load entries 0-4 as x10=0x000007FF, x11=0xFFFFF800, x12=0x000007FF, x13=0x80000000, x14=0x00000001. Start, drive matching writebacks, pulse halt → done 6 cycles after halt (NUM_CHECKS+1 with NUM_CHECKS=5), pass=1, fail_count=0, timed_out=0.
- Same table, but x13 is written as 0x7FFFFFFF and x11 as 0 → fail_count=2, first_fail_idx=1, first_fail_got=0x00000000, pass=0.
- TIMEOUT_CYCLES=20, all writebacks correct, no halt → CHECK entered after 20 RUN cycles, timed_out=1, pass=0, fail_count=0.
- Entry 0 checks x0 expecting 0; writeback wb_rd=0, wb_data=0xDEADBEEF; plus a writeback to x10 in the same cycle as halt → x0 check passes and the x10 value is captured.
- Reset pulsed during CHECK → all outputs 0 immediately. Reprogram the table and start → a clean run passes, proving shadow and results were cleared.
- Two back-to-back runs from DONE: the first fails, the second passes with correct data → the second reports pass=1, fail_count=0, and the table is retained without reprogramming.
